// File: rtl/counter_dispatcher_pkg.sv
// Shared constants and helpers for the customer-queue dispatcher.
// Ticket numbers run 1..15; 0 is reserved to mean "no customer".
package counter_dispatcher_pkg;

  localparam int NUM_W      = 4;
  localparam int TICKET_MIN = 1;
  localparam int TICKET_MAX = 15;
  localparam int DEF_TIME_W = 4;
  localparam int IDLE_NUM   = 0;

  // Ticket numbers skip the idle value when they wrap.
  function automatic logic [NUM_W-1:0] next_ticket(input logic [NUM_W-1:0] n);
    if (n == NUM_W'(TICKET_MAX)) return NUM_W'(TICKET_MIN);
    else                         return n + NUM_W'(1);
  endfunction

endpackage

// File: rtl/cust_fifo.sv
// Synchronous FIFO holding {ticket, service time} entries for waiting customers.
// Push is ignored when full and pop is ignored when empty.
module cust_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/counter_dispatcher.sv
// Customer-queue scheduler: issues tickets, queues arrivals and dispatches the
// queue head to a free service counter with a one-cycle load pulse, round-robin.
module counter_dispatcher
  import counter_dispatcher_pkg::*;
#(
  parameter int N_CTR   = 3,
  parameter int TIME_W  = DEF_TIME_W,
  parameter int Q_DEPTH = 8,
  parameter int Q_AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              arr_vld,
  input  logic [TIME_W-1:0] arr_time,
  output logic              arr_rdy,
  output logic [NUM_W-1:0]  next_num,
  input  logic [N_CTR-1:0]  ctr_busy,
  output logic [N_CTR-1:0]  ld,
  output logic [NUM_W-1:0]  dn,
  output logic [TIME_W-1:0] dt,
  output logic [Q_AW:0]     q_cnt,
  output logic [7:0]        served
);

  localparam int RR_W  = (N_CTR > 1) ? $clog2(N_CTR) : 1;
  localparam int ENT_W = NUM_W + TIME_W;

  logic [RR_W-1:0]   rr;
  logic [TIME_W-1:0] time_c;
  logic [ENT_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              accept;
  logic [N_CTR-1:0]  elig;
  logic              pick_ok;
  logic [RR_W-1:0]   pick_idx;
  logic [RR_W:0]     sum;
  logic              fire;

  // Arrival handshake: a customer is taken on any rising edge where arr_vld and
  // arr_rdy are both high; arr_rdy depends only on fullness, never on a
  // same-cycle dispatch, so the source may hold arr_vld until it sees arr_rdy.
  assign arr_rdy = !full;
  assign accept  = arr_vld && !full;
  assign time_c  = (arr_time == '0) ? TIME_W'(1) : arr_time;

  cust_fifo #(
    .W     (ENT_W),
    .DEPTH (Q_DEPTH),
    .AW    (Q_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (fire),
    .din   ({next_num, time_c}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (q_cnt)
  );

  // A counter pulsed last cycle has not raised busy yet, so mask it with ld.
  always_comb begin
    elig     = ~ctr_busy & ~ld;
    pick_ok  = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int k = 0; k < N_CTR; k++) begin
      sum = {1'b0, rr} + (RR_W+1)'(k);
      if (sum >= (RR_W+1)'(N_CTR)) sum = sum - (RR_W+1)'(N_CTR);
      if (!pick_ok && elig[sum[RR_W-1:0]]) begin
        pick_ok  = 1'b1;
        pick_idx = sum[RR_W-1:0];
      end
    end
    fire = en && !empty && pick_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld       <= '0;
      dn       <= NUM_W'(IDLE_NUM);
      dt       <= '0;
      rr       <= '0;
      served   <= '0;
      next_num <= NUM_W'(TICKET_MIN);
    end else begin
      if (accept) next_num <= next_ticket(next_num);
      if (fire) begin
        ld     <= N_CTR'(1) << pick_idx;
        dn     <= head[ENT_W-1 -: NUM_W];
        dt     <= head[TIME_W-1:0];
        rr     <= (pick_idx == RR_W'(N_CTR-1)) ? '0 : pick_idx + RR_W'(1);
        served <= served + 8'd1;
      end else begin
        ld <= '0;
        dn <= NUM_W'(IDLE_NUM);
        dt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_counter_dispatcher.sv
// Bench for counter_dispatcher: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_counter_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       arr_vld;
  logic [3:0] arr_time;
  logic       arr_rdy;
  logic [3:0] next_num;
  logic [2:0] ctr_busy;
  logic [2:0] ld;
  logic [3:0] dn;
  logic [3:0] dt;
  logic [3:0] q_cnt;
  logic [7:0] served;

  counter_dispatcher dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .arr_vld  (arr_vld),
    .arr_time (arr_time),
    .arr_rdy  (arr_rdy),
    .next_num (next_num),
    .ctr_busy (ctr_busy),
    .ld       (ld),
    .dn       (dn),
    .dt       (dt),
    .q_cnt    (q_cnt),
    .served   (served)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: waiting customers as {ticket, time}, plus output state
  logic [7:0] exp_q[$];
  int m_next, m_rr, m_ld, m_dn, m_dt, m_served;
  int dn_log[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_next = 1; m_rr = 0; m_ld = 0; m_dn = 0; m_dt = 0; m_served = 0;
  endtask

  // One clock of the dispatcher's rules, evaluated on the pre-edge state.
  task automatic model_step(input int e, input int v, input int t, input int b);
    int was_full, pick;
    was_full = (exp_q.size() == 8);
    pick = -1;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_rr + k) % 3;
      if (pick < 0 && ((b >> c) & 1) == 0 && ((m_ld >> c) & 1) == 0) pick = c;
    end
    if (e != 0 && exp_q.size() > 0 && pick >= 0) begin
      logic [7:0] h;
      h = exp_q.pop_front();
      m_ld = 1 << pick;
      m_dn = int'(h[7:4]);
      m_dt = int'(h[3:0]);
      m_rr = (pick + 1) % 3;
      m_served = (m_served + 1) % 256;
    end else begin
      m_ld = 0; m_dn = 0; m_dt = 0;
    end
    if (v != 0 && !was_full) begin
      exp_q.push_back({4'(m_next), 4'((t == 0) ? 1 : t)});
      m_next = (m_next == 15) ? 1 : m_next + 1;
    end
  endtask

  task automatic compare_all();
    check("ld", int'(ld), m_ld);
    check("dn", int'(dn), m_dn);
    check("dt", int'(dt), m_dt);
    check("q_cnt", int'(q_cnt), exp_q.size());
    check("served", int'(served), m_served);
    check("next_num", int'(next_num), m_next);
    check("arr_rdy", int'(arr_rdy), (exp_q.size() < 8) ? 1 : 0);
  endtask

  // driver: inputs change at negedge, outputs sampled 1ns after posedge
  task automatic step(input int e, input int v, input int t, input int b);
    @(negedge clk);
    en = e[0]; arr_vld = v[0]; arr_time = t[3:0]; ctr_busy = b[2:0];
    model_step(e, v, t, b);
    @(posedge clk);
    #1;
    compare_all();
    if (ld != 0) dn_log.push_back(int'(dn));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; arr_vld = 1'b0; arr_time = '0; ctr_busy = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();
  endtask

  typedef struct {
    int e, v, t, b;
    int exp_ld, exp_dn, exp_dt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; en = 1'b0; arr_vld = 1'b0; arr_time = '0; ctr_busy = '0;
    model_reset();

    // directed table: three arrivals to idle counters, then a zero-time arrival
    vecs.push_back('{1, 1, 2, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 3, 0, 1, 1, 2});
    vecs.push_back('{1, 1, 4, 0, 2, 2, 3});
    vecs.push_back('{1, 0, 0, 0, 4, 3, 4});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 4, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].e, vecs[i].v, vecs[i].t, vecs[i].b);
      check($sformatf("vec%0d_ld", i), int'(ld), vecs[i].exp_ld);
      check($sformatf("vec%0d_dn", i), int'(dn), vecs[i].exp_dn);
      check($sformatf("vec%0d_dt", i), int'(dt), vecs[i].exp_dt);
    end
    check("served_after_table", int'(served), 4);

    // full queue: 8 arrivals with all counters busy, 9th ignored, then free counter 1
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, 5, 7);
    check("full_arr_rdy", int'(arr_rdy), 0);
    check("full_q_cnt", int'(q_cnt), 8);
    step(1, 1, 5, 7);
    check("ignored_q_cnt", int'(q_cnt), 8);
    check("ignored_next_num", int'(next_num), 9);
    step(1, 0, 0, 5);
    check("release_ld", int'(ld), 2);
    check("release_dn", int'(dn), 1);
    check("release_q_cnt", int'(q_cnt), 7);

    // ticket wrap: 16 arrivals to idle counters
    do_reset();
    dn_log.delete();
    for (int i = 0; i < 16; i++) step(1, 1, $urandom_range(1, 15), 0);
    repeat (3) step(1, 0, 0, 0);
    check("wrap_count", dn_log.size(), 16);
    for (int i = 0; i < dn_log.size(); i++) begin
      check($sformatf("wrap_dn%0d", i), dn_log[i], (i % 15) + 1);
    end

    // dispatch disabled: queue holds, then resumes in order
    do_reset();
    step(0, 1, 6, 0);
    step(0, 1, 7, 0);
    repeat (3) begin
      step(0, 0, 0, 0);
      check("hold_ld", int'(ld), 0);
    end
    check("hold_q_cnt", int'(q_cnt), 2);
    step(1, 0, 0, 0);
    check("resume1_dn", int'(dn), 1);
    check("resume1_dt", int'(dt), 6);
    step(1, 0, 0, 0);
    check("resume2_dn", int'(dn), 2);
    check("resume2_ld", int'(ld), 2);

    // asynchronous reset while dispatching with 5 waiting
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 9, 7);
    step(1, 0, 0, 3);
    check("pre_rst_ld", int'(ld), 4);
    check("pre_rst_q_cnt", int'(q_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ld", int'(ld), 0);
    check("rst_dn", int'(dn), 0);
    check("rst_dt", int'(dt), 0);
    check("rst_q_cnt", int'(q_cnt), 0);
    model_reset();
    @(negedge clk);
    en = 1'b0; arr_vld = 1'b0; ctr_busy = '0;
    rst_n = 1'b1;
    #1;
    check("rst_next_num", int'(next_num), 1);
    check("rst_arr_rdy", int'(arr_rdy), 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 7));
    end
    repeat (20) step(1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
